// File: rtl/dct_block_sequencer_pkg.sv
// Shared types and constants for the 8x8 coefficient block sequencer.
package dct_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int COEF_PER_BLK = 64;
    localparam int COEF_IDX_W   = 6;

    localparam logic ORDER_RASTER = 1'b0;
    localparam logic ORDER_ZIGZAG = 1'b1;

    // Index of the final coefficient of a block.
    localparam logic [COEF_IDX_W-1:0] LAST_COEF_IDX = 6'(COEF_PER_BLK - 1);

endpackage

// File: rtl/dct_block_sequencer_zigzag_lut.sv
// Constant JPEG zigzag table: scan index -> (row u, column v).
module zigzag_lut
    import dct_seq_pkg::*;
(
    input  logic [COEF_IDX_W-1:0] idx_i,
    output logic [2:0]            u_o,
    output logic [2:0]            v_o
);

    logic [5:0] uv_s;  // octal digit pair {u, v}

    // Table lookup; each entry is written as octal 'uv'.
    always_comb begin
        uv_s = 6'o00;
        case (idx_i)
            6'd0:  uv_s = 6'o00;  6'd1:  uv_s = 6'o01;  6'd2:  uv_s = 6'o10;  6'd3:  uv_s = 6'o20;
            6'd4:  uv_s = 6'o11;  6'd5:  uv_s = 6'o02;  6'd6:  uv_s = 6'o03;  6'd7:  uv_s = 6'o12;
            6'd8:  uv_s = 6'o21;  6'd9:  uv_s = 6'o30;  6'd10: uv_s = 6'o40;  6'd11: uv_s = 6'o31;
            6'd12: uv_s = 6'o22;  6'd13: uv_s = 6'o13;  6'd14: uv_s = 6'o04;  6'd15: uv_s = 6'o05;
            6'd16: uv_s = 6'o14;  6'd17: uv_s = 6'o23;  6'd18: uv_s = 6'o32;  6'd19: uv_s = 6'o41;
            6'd20: uv_s = 6'o50;  6'd21: uv_s = 6'o60;  6'd22: uv_s = 6'o51;  6'd23: uv_s = 6'o42;
            6'd24: uv_s = 6'o33;  6'd25: uv_s = 6'o24;  6'd26: uv_s = 6'o15;  6'd27: uv_s = 6'o06;
            6'd28: uv_s = 6'o07;  6'd29: uv_s = 6'o16;  6'd30: uv_s = 6'o25;  6'd31: uv_s = 6'o34;
            6'd32: uv_s = 6'o43;  6'd33: uv_s = 6'o52;  6'd34: uv_s = 6'o61;  6'd35: uv_s = 6'o70;
            6'd36: uv_s = 6'o71;  6'd37: uv_s = 6'o62;  6'd38: uv_s = 6'o53;  6'd39: uv_s = 6'o44;
            6'd40: uv_s = 6'o35;  6'd41: uv_s = 6'o26;  6'd42: uv_s = 6'o17;  6'd43: uv_s = 6'o27;
            6'd44: uv_s = 6'o36;  6'd45: uv_s = 6'o45;  6'd46: uv_s = 6'o54;  6'd47: uv_s = 6'o63;
            6'd48: uv_s = 6'o72;  6'd49: uv_s = 6'o73;  6'd50: uv_s = 6'o64;  6'd51: uv_s = 6'o55;
            6'd52: uv_s = 6'o46;  6'd53: uv_s = 6'o37;  6'd54: uv_s = 6'o47;  6'd55: uv_s = 6'o56;
            6'd56: uv_s = 6'o65;  6'd57: uv_s = 6'o74;  6'd58: uv_s = 6'o75;  6'd59: uv_s = 6'o66;
            6'd60: uv_s = 6'o57;  6'd61: uv_s = 6'o67;  6'd62: uv_s = 6'o76;  6'd63: uv_s = 6'o77;
            default: uv_s = 6'o00;
        endcase
    end

    assign u_o = uv_s[5:3];
    assign v_o = uv_s[2:0];

endmodule

// File: rtl/dct_block_sequencer.sv
// Frame scheduler: emits 64 (u,v) coordinates per block, raster or zigzag,
// under a valid/ready handshake, with last-coef/last-block flags and a
// one-cycle frame completion pulse.
module dct_block_sequencer
    import dct_seq_pkg::*;
#(
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [BLK_CNT_W-1:0] num_blocks,
    input  logic                 zz_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_u,
    output logic [2:0]           out_v,
    output logic                 out_last_coef,
    output logic                 out_last_blk,
    output logic                 busy,
    output logic                 frame_done
);

    seq_state_t            state_q;
    logic [COEF_IDX_W-1:0] idx_q;
    logic [BLK_CNT_W-1:0]  blk_q;
    logic [BLK_CNT_W-1:0]  tot_q;
    logic                  mode_q;

    logic                  beat_s;
    logic                  is_last_blk_s;
    logic [2:0]            zz_u_s;
    logic [2:0]            zz_v_s;

    // tot_q is only zero for empty jobs, which never enter RUN; the guard
    // keeps tot_q-1 from ever being evaluated as an all-ones wrap.
    assign is_last_blk_s = (tot_q != BLK_CNT_W'(0)) && (blk_q == tot_q - BLK_CNT_W'(1));
    assign beat_s        = out_valid & out_ready;

    // Control FSM with the coefficient/block counters and latched job fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            blk_q   <= '0;
            tot_q   <= '0;
            mode_q  <= ORDER_RASTER;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        tot_q   <= num_blocks;
                        mode_q  <= zz_mode;
                        idx_q   <= '0;
                        blk_q   <= '0;
                        state_q <= (num_blocks == BLK_CNT_W'(0)) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (beat_s) begin
                        idx_q <= idx_q + 6'd1;
                        if (idx_q == LAST_COEF_IDX) begin
                            blk_q <= blk_q + BLK_CNT_W'(1);
                            if (is_last_blk_s) begin
                                state_q <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    zigzag_lut u_zigzag_lut (
        .idx_i (idx_q),
        .u_o   (zz_u_s),
        .v_o   (zz_v_s)
    );

    // All outputs decode registered state only, so none depends on a
    // same-cycle handshake input.
    assign start_ready   = (state_q == IDLE);
    assign out_valid     = (state_q == RUN);
    assign busy          = (state_q != IDLE);
    assign frame_done    = (state_q == DONE);
    assign out_u         = (mode_q == ORDER_ZIGZAG) ? zz_u_s : idx_q[5:3];
    assign out_v         = (mode_q == ORDER_ZIGZAG) ? zz_v_s : idx_q[2:0];
    assign out_last_coef = (idx_q == LAST_COEF_IDX) & out_valid;
    assign out_last_blk  = is_last_blk_s & out_valid;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Directed bench for dct_block_sequencer: reset, raster and zigzag frames,
// backpressure, empty and ignored starts, reset mid-frame.
module tb_dct_block_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] num_blocks;
    logic        zz_mode;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_u;
    logic [2:0]  out_v;
    logic        out_last_coef;
    logic        out_last_blk;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dct_block_sequencer #(.BLK_CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .num_blocks    (num_blocks),
        .zz_mode       (zz_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_u         (out_u),
        .out_v         (out_v),
        .out_last_coef (out_last_coef),
        .out_last_blk  (out_last_blk),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    // Expected (u,v) for coefficient k; zigzag is produced by walking the
    // anti-diagonals, alternating direction, independent of any table.
    function automatic logic [5:0] exp_uv(input bit zz, input int k);
        int n;
        logic [5:0] r;
        r = 6'(k);
        if (zz) begin
            n = 0;
            for (int s = 0; s < 15; s++) begin
                int lo, hi;
                lo = (s > 7) ? s - 7 : 0;
                hi = (s < 7) ? s : 7;
                if (s % 2 == 0) begin
                    for (int u = hi; u >= lo; u--) begin
                        if (n == k) r = {3'(u), 3'(s - u)};
                        n++;
                    end
                end else begin
                    for (int u = lo; u <= hi; u++) begin
                        if (n == k) r = {3'(u), 3'(s - u)};
                        n++;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start_valid = 1'b0; num_blocks = 16'd0; zz_mode = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL reset_start_ready got %b want 1", start_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        n_cmp++; if ({out_u, out_v, out_last_coef, out_last_blk} !== 8'h00) begin
            n_err++; $display("FAIL reset_coord_flags got u=%0d v=%0d lc=%b lb=%b want all 0", out_u, out_v, out_last_coef, out_last_blk);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one frame; ready_pct sets out_ready duty, inject pulses start_valid mid-frame.
    task automatic run_frame(input int nb, input bit zz, input int ready_pct, input bit inject);
        int b, cyc, last_cyc, done_cyc, total;
        bit done_seen, prev_stall;
        logic [2:0] pu, pv;
        logic [5:0] euv;
        n_cmp++; if (start_ready !== 1'b1) begin n_err++; $display("FAIL pre_start_ready got %b want 1", start_ready); end
        start_valid = 1'b1; num_blocks = 16'(nb); zz_mode = zz; out_ready = 1'b0;
        @(negedge clk);
        start_valid = 1'b0; num_blocks = 16'hFFFF; zz_mode = ~zz;
        total = 64 * nb; b = 0; cyc = 0; last_cyc = -1; done_cyc = -1;
        done_seen = 1'b0; prev_stall = 1'b0; pu = 3'd0; pv = 3'd0;
        while (!done_seen && cyc < total * 4 + 20) begin
            if (frame_done === 1'b1) begin
                done_seen = 1'b1; done_cyc = cyc; start_valid = 1'b0; out_ready = 1'b0;
                n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL done_out_valid got %b want 0", out_valid); end
            end else begin
                n_cmp++; if (out_valid !== 1'(b < total)) begin
                    n_err++; $display("FAIL out_valid beat %0d got %b want %b", b, out_valid, (b < total));
                end
                if (out_valid === 1'b1 && b < total) begin
                    euv = exp_uv(zz, b % 64);
                    n_cmp++; if ({out_u, out_v} !== euv) begin
                        n_err++; $display("FAIL coord beat %0d got (%0d,%0d) want (%0d,%0d)", b, out_u, out_v, euv[5:3], euv[2:0]);
                    end
                    n_cmp++; if (out_last_coef !== 1'(b % 64 == 63)) begin
                        n_err++; $display("FAIL last_coef beat %0d got %b want %b", b, out_last_coef, (b % 64 == 63));
                    end
                    n_cmp++; if (out_last_blk !== 1'(b / 64 == nb - 1)) begin
                        n_err++; $display("FAIL last_blk beat %0d got %b want %b", b, out_last_blk, (b / 64 == nb - 1));
                    end
                    if (prev_stall) begin
                        n_cmp++; if ({out_u, out_v} !== {pu, pv}) begin
                            n_err++; $display("FAIL stall_hold beat %0d got (%0d,%0d) want (%0d,%0d)", b, out_u, out_v, pu, pv);
                        end
                    end
                end
                start_valid = (inject && b >= 10 && b < 14) ? 1'b1 : 1'b0;
                out_ready   = ($urandom_range(99) < ready_pct) ? 1'b1 : 1'b0;
                prev_stall  = (out_valid === 1'b1) && !out_ready;
                pu = out_u; pv = out_v;
                if (out_valid === 1'b1 && out_ready) begin
                    b++; last_cyc = cyc;
                end
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (!done_seen) begin n_err++; $display("FAIL frame_timeout got no frame_done want one within %0d cycles", total * 4 + 20); end
        n_cmp++; if (b !== total) begin n_err++; $display("FAIL beat_count got %0d want %0d", b, total); end
        n_cmp++; if (done_cyc !== last_cyc + 1) begin n_err++; $display("FAIL done_timing got cycle %0d want %0d", done_cyc, last_cyc + 1); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got %b want 0", frame_done); end
        n_cmp++; if (start_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL post_idle got start_ready=%b busy=%b want 1/0", start_ready, busy);
        end
    endtask

    task automatic test_raster();
        run_frame(2, 1'b0, 100, 1'b0);
    endtask

    task automatic test_zigzag();
        run_frame(1, 1'b1, 100, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame(2, 1'b1, 50, 1'b0);
        run_frame(3, 1'b0, 50, 1'b0);
    endtask

    task automatic test_zero_and_illegal();
        start_valid = 1'b1; num_blocks = 16'd0; zz_mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL zero_done got %b want 1", frame_done); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zero_out_valid got %b want 0", out_valid); end
        n_cmp++; if (start_ready !== 1'b0) begin n_err++; $display("FAIL zero_start_ready_done got %b want 0", start_ready); end
        @(negedge clk);
        n_cmp++; if (frame_done !== 1'b0 || start_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL zero_after got done=%b ready=%b valid=%b want 0/1/0", frame_done, start_ready, out_valid);
        end
        run_frame(1, 1'b0, 100, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int b, cyc;
        start_valid = 1'b1; num_blocks = 16'd2; zz_mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        b = 0; cyc = 0;
        while (b < 30 && cyc < 100) begin
            if (out_valid === 1'b1) b++;
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if ({out_valid, out_u, out_v} !== {1'b1, 3'd3, 3'd6}) begin
            n_err++; $display("FAIL mid_beat30 got valid=%b (%0d,%0d) want 1 (3,6)", out_valid, out_u, out_v);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1 || frame_done !== 1'b0) begin
            n_err++; $display("FAIL mid_reset got valid=%b busy=%b ready=%b done=%b want 0/0/1/0", out_valid, busy, start_ready, frame_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
                n_err++; $display("FAIL mid_after got done=%b valid=%b want 0/0", frame_done, out_valid);
            end
        end
        run_frame(1, 1'b0, 100, 1'b0);
    endtask

    initial begin
        test_reset();
        test_raster();
        test_zigzag();
        test_backpressure();
        test_zero_and_illegal();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
